// File: rtl/idiv_fu_pkg.sv
// Shared definitions for the iterative integer divide FU.
// cpu_params_pkg  : datapath widths and special-result constants.
// cpu_structs_pkg : the divide operation encoding seen by EXE.
// idiv_fu_pkg     : FSM state type and small op-decoding helpers.
package cpu_params_pkg;
    localparam int XLEN  = 32;
    localparam int RSZ   = 32;
    localparam int CNT_W = 5;

    localparam logic [XLEN-1:0] DIV0_QUO = 32'hFFFFFFFF;
    localparam logic [XLEN-1:0] OVF_QUO  = 32'h80000000;
endpackage

package cpu_structs_pkg;
    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } IDIV_OP_TYPE;
endpackage

package idiv_fu_pkg;
    import cpu_structs_pkg::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } idiv_state_e;

    function automatic logic op_is_signed(input IDIV_OP_TYPE op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input IDIV_OP_TYPE op);
        return (op == REM) || (op == REMU);
    endfunction
endpackage

// File: rtl/idiv_fu_if.sv
// EXE <-> divide FU handshake bundle. EXE is the master, the FU the slave.
interface idiv_fu_if;
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;

    logic            start_in;
    IDIV_OP_TYPE     op;
    logic [XLEN-1:0] Rs1_data;
    logic [XLEN-1:0] Rs2_data;
    logic            flush_in;
    logic            ready_out;
    logic            valid_out;
    logic [XLEN-1:0] Rd_data;

    modport master (
        output start_in, op, Rs1_data, Rs2_data, flush_in,
        input  ready_out, valid_out, Rd_data
    );

    modport slave (
        input  start_in, op, Rs1_data, Rs2_data, flush_in,
        output ready_out, valid_out, Rd_data
    );
endinterface

// File: rtl/idiv_fu_div.sv
// sr_div32: unsigned radix-2 restoring divide datapath. One quotient bit
// per step; the dividend is shifted out of quo while quotient bits shift in.
module sr_div32
    import cpu_params_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            last,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);
    logic [XLEN-1:0]  dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;
    logic             borrow;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        borrow  = diff[XLEN];
    end

    assign last = (cnt_q == '0);

    // Load operands, then iterate once per step, restoring on borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            quo   <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem   <= '0;
            quo   <= dividend;
            dvs_q <= divisor;
            cnt_q <= CNT_W'(XLEN - 1);
        end else if (step) begin
            rem <= borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            quo <= {quo[XLEN-2:0], ~borrow};
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end
endmodule

// File: rtl/idiv_fu.sv
// idiv_fu: multi-cycle RV32M DIV/DIVU/REM/REMU unit. Works on operand
// magnitudes through sr_div32 and applies the signs when the result is
// registered. Divide-by-zero and signed overflow skip the iteration.
// Optional build macro IDIV_EARLY_OUT_EN: when |Rs1| < |Rs2| the result is
// known at accept (quotient 0, remainder Rs1) and also skips the iteration.
module idiv_fu
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
    import idiv_fu_pkg::*;
(
    input logic      clk_in,
    input logic      reset_in,
    idiv_fu_if.slave bus
);
    idiv_state_e     state_q;
    logic            ready_q;
    logic            valid_q;
    logic [XLEN-1:0] rd_q;
    logic            is_rem_q;
    logic            neg_q;
    logic            use_special_q;
    logic [XLEN-1:0] special_q;

    logic            signed_op;
    logic            rem_op;
    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            overflow;
    logic            early_out;
    logic            take_special;
    logic [XLEN-1:0] special_val;
    logic            accept;
    logic            div_load;
    logic            div_step;
    logic            div_last;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] raw_res;
    logic [XLEN-1:0] fixed_res;

    // Decode the incoming request: magnitudes, signs and the short-cut cases.
    always_comb begin
        signed_op = op_is_signed(bus.op);
        rem_op    = op_is_rem(bus.op);
        sign1     = signed_op & bus.Rs1_data[XLEN-1];
        sign2     = signed_op & bus.Rs2_data[XLEN-1];
        mag1      = sign1 ? (~bus.Rs1_data + 1'b1) : bus.Rs1_data;
        mag2      = sign2 ? (~bus.Rs2_data + 1'b1) : bus.Rs2_data;
        div_zero  = (bus.Rs2_data == '0);
        overflow  = signed_op && (bus.Rs1_data == OVF_QUO) && (bus.Rs2_data == '1);
        if (div_zero) begin
            special_val = rem_op ? bus.Rs1_data : DIV0_QUO;
        end else if (overflow) begin
            special_val = rem_op ? '0 : OVF_QUO;
        end else begin
            special_val = rem_op ? bus.Rs1_data : '0;
        end
    end

`ifdef IDIV_EARLY_OUT_EN
    assign early_out = !div_zero && (mag1 < mag2);
`else
    assign early_out = 1'b0;
`endif

    assign take_special = div_zero || overflow || early_out;
    assign accept       = (state_q == IDLE) && ready_q && bus.start_in && !bus.flush_in;
    assign div_load     = accept && !take_special;
    assign div_step     = (state_q == CALC) && !bus.flush_in;

    sr_div32 u_div (
        .clk      (clk_in),
        .rst_n    (reset_in),
        .load     (div_load),
        .step     (div_step),
        .dividend (mag1),
        .divisor  (mag2),
        .last     (div_last),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    // Pick quotient or remainder and restore the sign.
    always_comb begin
        raw_res   = is_rem_q ? div_rem : div_quo;
        fixed_res = neg_q ? (~raw_res + 1'b1) : raw_res;
    end

    // Control FSM with registered ready/valid/result; flush overrides everything.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            valid_q       <= 1'b0;
            rd_q          <= '0;
            is_rem_q      <= 1'b0;
            neg_q         <= 1'b0;
            use_special_q <= 1'b0;
            special_q     <= '0;
        end else if (bus.flush_in) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (accept) begin
                        ready_q       <= 1'b0;
                        is_rem_q      <= rem_op;
                        neg_q         <= rem_op ? sign1 : (sign1 ^ sign2);
                        use_special_q <= take_special;
                        special_q     <= special_val;
                        state_q       <= take_special ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (div_last) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b1;
                    ready_q <= 1'b1;
                    rd_q    <= use_special_q ? special_q : fixed_res;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_out = ready_q;
    assign bus.valid_out = valid_q;
    assign bus.Rd_data   = rd_q;
endmodule

// File: tb/tb_idiv_fu.sv
// Scoreboard bench for idiv_fu: the driver pushes reference results computed
// with plain integer arithmetic, the monitor pops them on each valid_out.
module tb_idiv_fu;
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    logic clk_in   = 1'b0;
    logic reset_in = 1'b1;
    int   cycle    = 0;
    int   vectors  = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    idiv_fu_if bus ();

    idiv_fu dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cycle++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Reference model straight from the ISA rules using 64-bit integers.
    function automatic void ref_model(input logic [1:0] opv, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output int lat);
        longint sa, sb, ua, ub, m1, m2;
        bit     sgn, special;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        sgn = (opv == 2'd0) || (opv == 2'd2);
        special = 1'b0;
        res = 32'd0;
        if (b == 32'd0) begin
            special = 1'b1;
            res = (opv >= 2'd2) ? a : 32'hFFFFFFFF;
        end else if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            special = 1'b1;
            res = (opv == 2'd0) ? 32'h80000000 : 32'h00000000;
        end else begin
            case (opv)
                2'd0: res = 32'(sa / sb);
                2'd1: res = 32'(ua / ub);
                2'd2: res = 32'(sa % sb);
                default: res = 32'(ua % ub);
            endcase
        end
        m1 = sgn ? ((sa < 0) ? -sa : sa) : ua;
        m2 = sgn ? ((sb < 0) ? -sb : sb) : ub;
        lat = special ? 1 : 33;
`ifdef IDIV_EARLY_OUT_EN
        if (!special && m1 < m2) lat = 1;
`endif
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk_in);
        while (bus.ready_out !== 1'b1 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (bus.ready_out !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ready_timeout: ready_out=%b after %0d cycles, expected 1", bus.ready_out, n);
        end
    endtask

    // Issue one operation at a negedge; optionally record its expected result.
    task automatic apply_stimulus(input logic [1:0] opv, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        wait_ready();
        bus.op       = IDIV_OP_TYPE'(opv);
        bus.Rs1_data = a;
        bus.Rs2_data = b;
        bus.start_in = 1'b1;
        @(posedge clk_in);
        #1;
        bus.start_in = 1'b0;
        bus.Rs1_data = $urandom;
        bus.Rs2_data = $urandom;
        if (push) begin
            ref_model(opv, a, b, e.data, e.lat);
            e.acc = cycle;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: every valid_out pulse must match the oldest expectation.
    always @(negedge clk_in) begin
        if (reset_in === 1'b1 && bus.valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_valid: Rd_data=0x%08h with no operation pending", bus.Rd_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_output("rd_data", bus.Rd_data, e.data);
                check_output("latency", 32'(cycle - e.acc), 32'(e.lat));
            end
        end
    end

    initial begin
        int n;
        logic [1:0]  opv;
        logic [31:0] a, b;
        bus.start_in = 1'b0;
        bus.flush_in = 1'b0;
        bus.op       = DIV;
        bus.Rs1_data = '0;
        bus.Rs2_data = '0;
        #2 reset_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_output("reset_ready", 32'(bus.ready_out), 32'd1);
        check_output("reset_valid", 32'(bus.valid_out), 32'd0);
        check_output("reset_rd", bus.Rd_data, 32'd0);
        reset_in = 1'b1;

        $display("[TB] signed divide 20 / -3");
        apply_stimulus(2'd0, 32'd20, 32'hFFFFFFFD, 1);
        apply_stimulus(2'd2, 32'd20, 32'hFFFFFFFD, 1);

        $display("[TB] unsigned divide, ready_out busy window");
        apply_stimulus(2'd1, 32'hFFFFFFFF, 32'd2, 1);
        n = 0;
        forever begin
            @(negedge clk_in);
            if (bus.ready_out === 1'b1 || n >= 100) break;
            n++;
        end
        check_output("ready_low_cycles", 32'(n), 32'd33);
        apply_stimulus(2'd3, 32'hFFFFFFFF, 32'd2, 1);

        $display("[TB] divide by zero and signed overflow");
        for (int k = 0; k < 4; k++) apply_stimulus(2'(k), 32'h12345678, 32'd0, 1);
        apply_stimulus(2'd0, 32'h80000000, 32'hFFFFFFFF, 1);
        apply_stimulus(2'd2, 32'h80000000, 32'hFFFFFFFF, 1);

        $display("[TB] flush mid-operation");
        apply_stimulus(2'd1, 32'd100, 32'd7, 0);
        repeat (9) @(negedge clk_in);
        bus.flush_in = 1'b1;
        @(negedge clk_in);
        bus.flush_in = 1'b0;
        check_output("flush_ready", 32'(bus.ready_out), 32'd1);
        repeat (40) @(negedge clk_in);
        bus.op = DIVU; bus.Rs1_data = 32'd100; bus.Rs2_data = 32'd7;
        bus.start_in = 1'b1;
        bus.flush_in = 1'b1;
        @(negedge clk_in);
        bus.start_in = 1'b0;
        bus.flush_in = 1'b0;
        check_output("flush_start_ready", 32'(bus.ready_out), 32'd1);
        repeat (40) @(negedge clk_in);
        apply_stimulus(2'd1, 32'd100, 32'd7, 1);

        $display("[TB] reset mid-operation");
        apply_stimulus(2'd1, 32'd100, 32'd7, 0);
        repeat (9) @(negedge clk_in);
        reset_in = 1'b0;
        #1;
        check_output("midreset_ready", 32'(bus.ready_out), 32'd1);
        check_output("midreset_valid", 32'(bus.valid_out), 32'd0);
        check_output("midreset_rd", bus.Rd_data, 32'd0);
        @(negedge clk_in);
        reset_in = 1'b1;
        repeat (40) @(negedge clk_in);

        $display("[TB] small dividend over large divisor");
        apply_stimulus(2'd1, 32'd3, 32'd10, 1);
        apply_stimulus(2'd3, 32'd3, 32'd10, 1);
        apply_stimulus(2'd2, 32'hFFFFFFFD, 32'd10, 1);

        $display("[TB] randomized operations");
        for (int k = 0; k < 40; k++) begin
            opv = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: a = $urandom_range(0, 1000);
                3: b = $urandom_range(1, 15);
                4: b = 32'hFFFFFFFF - $urandom_range(0, 15);
                default: ;
            endcase
            apply_stimulus(opv, a, b, 1);
        end

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        repeat (3) @(negedge clk_in);
        check_output("pending_results", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
